// File: rtl/pipe_hazard_unit_pkg.sv
// Shared pipeline definitions: hazard FSM states, the zero register, and the
// ID/EX control-field NOP pattern used when a bubble is inserted.
package pipe_hazard_unit_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        STALL    = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       reg_dst;
        logic [1:0] alu_op;
    } idex_ctrl_t;

    // A zeroed control word never writes the register file or memory.
    localparam idex_ctrl_t IDEX_NOP_CTRL = '0;

    function automatic logic load_use_hit(
        input logic       ex_mem_read,
        input logic [4:0] ex_rt,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt,
        input logic       id_uses_rt
    );
        return ex_mem_read && (ex_rt != REG_ZERO) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    endfunction

endpackage

// File: rtl/pipe_hazard_unit_if.sv
// Signal bundle between the ID-stage pipeline logic (master) and the hazard
// unit (slave).
interface pipe_hazard_unit_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       IFID_RegisterRs;
    logic [4:0]       IFID_RegisterRt;
    logic             IFID_UsesRt;
    logic             IDEX_MemRead;
    logic [4:0]       IDEX_RegisterRt;
    logic             EX_BranchTaken;
    logic             dmem_busy;
    logic             PCWrite;
    logic             IFID_Write;
    logic             IFID_Flush;
    logic             IDEX_Bubble;
    logic             pipe_freeze;
    logic             dmem_timeout_err;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output IFID_RegisterRs, IFID_RegisterRt, IFID_UsesRt,
               IDEX_MemRead, IDEX_RegisterRt, EX_BranchTaken, dmem_busy,
        input  PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, pipe_freeze,
               dmem_timeout_err, stall_count, flush_count
    );

    modport slave (
        input  IFID_RegisterRs, IFID_RegisterRt, IFID_UsesRt,
               IDEX_MemRead, IDEX_RegisterRt, EX_BranchTaken, dmem_busy,
        output PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, pipe_freeze,
               dmem_timeout_err, stall_count, flush_count
    );
endinterface

// File: rtl/pipe_hazard_unit_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module hazard_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/pipe_hazard_unit.sv
// Load-use / branch-flush / data-memory-wait hazard controller beside the ID
// stage; control outputs are combinational from state plus current inputs.
module pipe_hazard_unit
    import pipe_hazard_unit_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int DMEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    pipe_hazard_unit_if.slave  hz
);
    localparam int WAIT_W = $clog2(DMEM_TIMEOUT + 1);

    hz_state_e         state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q, err_d;
    logic              stall_inc, flush_inc;
    logic              lu;
    logic              pc_write, ifid_write, ifid_flush, idex_bubble, freeze;

    assign lu = load_use_hit(hz.IDEX_MemRead, hz.IDEX_RegisterRt,
                             hz.IFID_RegisterRs, hz.IFID_RegisterRt,
                             hz.IFID_UsesRt);

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        freeze      = 1'b0;
        state_d     = state_q;
        wait_d      = wait_q;
        err_d       = err_q;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;

        if (reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else begin
            unique case (state_q)
                RUN, STALL: begin
                    if (hz.dmem_busy) begin
                        freeze     = 1'b1;
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        state_d    = MEM_WAIT;
                        wait_d     = WAIT_W'(1);
                    end else if (hz.EX_BranchTaken) begin
                        // Squashed ID instruction makes any load-use moot.
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                        flush_inc   = 1'b1;
                        state_d     = RUN;
                    end else if ((state_q == RUN) && lu) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                        stall_inc   = 1'b1;
                        state_d     = STALL;
                    end else begin
                        state_d = RUN;
                    end
                end
                MEM_WAIT: begin
                    if (!hz.dmem_busy) begin
                        state_d = RUN;
                    end else begin
                        freeze     = 1'b1;
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        // On timeout, release to RUN and let RUN re-sample busy.
                        if (wait_q >= WAIT_W'(DMEM_TIMEOUT)) begin
                            err_d   = 1'b1;
                            state_d = RUN;
                        end else begin
                            wait_d = wait_q + WAIT_W'(1);
                        end
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (hz.stall_count)
    );

    hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .count (hz.flush_count)
    );

    assign hz.PCWrite          = pc_write;
    assign hz.IFID_Write       = ifid_write;
    assign hz.IFID_Flush       = ifid_flush;
    assign hz.IDEX_Bubble      = idex_bubble;
    assign hz.pipe_freeze      = freeze;
    assign hz.dmem_timeout_err = err_q;
endmodule

// File: doc/pipe_hazard_unit.md
Name: pipe_hazard_unit

Overview:
- Hazard detection and pipeline stall/flush controller for the 5-stage MIPS pipeline; the counterpart of the forwarding unit.
- Forwarding resolves the dependences it can. This block stalls or flushes for the rest:
  - load-use hazards,
  - taken branches resolved in EX,
  - multi-cycle data-memory waits.
- Sits beside the ID stage.
- Drives the PC, IF/ID and ID/EX write enables, and the bubble/flush controls.

Parameters:
- CNT_W, 16, width of the saturating stall and flush event counters.
- DMEM_TIMEOUT, 15, maximum consecutive MEM_WAIT cycles before the error flag is set and the pipeline is released.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- IFID_RegisterRs  in  5  Rs field of the instruction in ID.
- IFID_RegisterRt  in  5  Rt field of the instruction in ID.
- IFID_UsesRt  in  1  instruction in ID reads Rt as a source (R-type, beq, sw).
- IDEX_MemRead  in  1  instruction in EX is a load.
- IDEX_RegisterRt  in  5  destination register of the load in EX.
- EX_BranchTaken  in  1  branch in EX resolved taken this cycle.
- dmem_busy  in  1  data memory has not completed the MEM-stage access.
- PCWrite  out  1  PC update enable.
- IFID_Write  out  1  IF/ID register write enable.
- IFID_Flush  out  1  IF/ID register loads a NOP.
- IDEX_Bubble  out  1  ID/EX control fields are zeroed (NOP inserted).
- pipe_freeze  out  1  EX/MEM and MEM/WB registers hold.
- dmem_timeout_err  out  1  sticky flag; cleared only by reset.
- stall_count  out  CNT_W  saturating count of load-use stall cycles.
- flush_count  out  CNT_W  saturating count of branch flushes.

Behaviour:
- Reset values (reset sampled high at the edge):
  - state=RUN; both counters 0; dmem_timeout_err 0.
  - While reset is high, outputs are forced to PCWrite=0, IFID_Write=0, IFID_Flush=1, IDEX_Bubble=1, pipe_freeze=0.
- Outputs are combinational from the registered state plus the current inputs, with zero-cycle latency. State and counters update on the next edge.
- Load-use condition (lu):
  - IDEX_MemRead=1, IDEX_RegisterRt!=0, and either IDEX_RegisterRt==IFID_RegisterRs, or (IFID_UsesRt=1 and IDEX_RegisterRt==IFID_RegisterRt).
- Priority, highest first: reset > dmem_busy > EX_BranchTaken > lu.
- Default outputs (no event): PCWrite=1, IFID_Write=1, all other controls 0.
- RUN state:
  - dmem_busy: pipe_freeze=1, PCWrite=0, IFID_Write=0, no bubble. Next state MEM_WAIT, wait counter cleared to 1.
  - Else EX_BranchTaken: IFID_Flush=1, IDEX_Bubble=1, PCWrite=1 (branch target loads). flush_count+1. Stay in RUN. lu is ignored because the ID instruction is squashed.
  - Else lu: PCWrite=0, IFID_Write=0, IDEX_Bubble=1. stall_count+1. Next state STALL.
- STALL state:
  - Lasts exactly one cycle; lu is not re-evaluated, since the bubble now occupies EX.
  - Default outputs. Next state RUN.
  - dmem_busy or EX_BranchTaken in this cycle is handled exactly as in RUN.
- MEM_WAIT state:
  - Outputs: pipe_freeze=1, PCWrite=0, IFID_Write=0, no bubble, no flush. EX_BranchTaken and lu are ignored (the EX stage is held).
  - dmem_busy=0: freeze drops the same cycle; default outputs; next state RUN.
  - Wait counter reaches DMEM_TIMEOUT with dmem_busy still 1: set dmem_timeout_err; next state RUN. The freeze is released the following cycle, where dmem_busy is evaluated afresh from RUN.
- Counters saturate at all-ones and never wrap.
- Reset asserted mid-stall or mid-wait aborts to RUN on that edge; no partial count increment.

Decomposition:
- Shared pipeline package holds:
  - the state enumeration RUN/STALL/MEM_WAIT (2-bit),
  - the REG_ZERO=5'd0 constant,
  - NOP control-field constants, shared with the ID/EX register.
- One natural sub-module: hazard_sat_counter (CNT_W-wide, synchronous reset, increment enable, saturating), instantiated twice.

Test Plan:
- Load-use: IDEX_MemRead=1, IDEX_RegisterRt=8, IFID_RegisterRs=8 -> one cycle with PCWrite=0, IFID_Write=0, IDEX_Bubble=1; next cycle defaults; stall_count=1.
- No false stall:
  - IDEX_RegisterRt=0 with Rs=0 -> no stall.
  - IFID_UsesRt=0 with Rt match only -> no stall.
- Branch over load-use: EX_BranchTaken=1 and lu=1 -> IFID_Flush=1, IDEX_Bubble=1, PCWrite=1; flush_count=1; stall_count=0.
- Memory wait: dmem_busy high for 3 cycles -> pipe_freeze=1 for exactly 3 cycles, then defaults; lu raised during the wait has no effect until RUN.
- Timeout: dmem_busy held high 20 cycles -> dmem_timeout_err=1 after 15 wait cycles, stays 1 until reset.
- Reset and saturation:
  - Reset asserted while in STALL -> RUN next edge, counters 0.
  - stall_count preloaded near max via repeated stalls with CNT_W=4 -> holds at 15.
